// File: rtl/uram_req_rsp_adapter_if.sv
// Request/response and URAM control bundle for the URAM front-end adapter.
// Latency: none, signal grouping only.
// Backpressure: req_ready/rsp_ready handshakes; the URAM side has none.
interface uram_req_rsp_adapter_if #(
    parameter int AWIDTH  = 12,
    parameter int NUM_COL = 9,
    parameter int DWIDTH  = 72
);
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [AWIDTH-1:0]  req_addr;
    logic [DWIDTH-1:0]  req_wdata;
    logic [NUM_COL-1:0] req_wstrb;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DWIDTH-1:0]  rsp_rdata;
    logic               uram_mem_en;
    logic [NUM_COL-1:0] uram_we;
    logic               uram_regce;
    logic [AWIDTH-1:0]  uram_addr;
    logic [DWIDTH-1:0]  uram_din;
    logic [DWIDTH-1:0]  uram_dout;

    // Adapter side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, uram_dout,
        output req_ready, rsp_valid, rsp_rdata,
        output uram_mem_en, uram_we, uram_regce, uram_addr, uram_din
    );

    // Requester + URAM side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, uram_dout,
        input  req_ready, rsp_valid, rsp_rdata,
        input  uram_mem_en, uram_we, uram_regce, uram_addr, uram_din
    );
endinterface

// File: rtl/uram_req_rsp_adapter.sv
// Valid/ready request stream to registered pipelined-URAM controls, read data into a response FIFO.
// Latency: URAM controls 1 cycle after accept; rsp_valid NBPIPE+3 cycles after a read accept.
// Backpressure: req_ready drops while RSP_DEPTH reads are outstanding, so returning data always fits.
module uram_req_rsp_adapter #(
    parameter int AWIDTH    = 12,
    parameter int NUM_COL   = 9,
    parameter int CWIDTH    = 8,
    parameter int DWIDTH    = 72,
    parameter int NBPIPE    = 3,
    parameter int RSP_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uram_req_rsp_adapter_if.slave bus
);
    localparam int LAT = NBPIPE + 2;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic               run_q;      // low in reset, high from the first edge after release
    logic               en_q;
    logic [NUM_COL-1:0] we_q;
    logic [AWIDTH-1:0]  addr_q;
    logic [DWIDTH-1:0]  din_q;
    logic [LAT:0]       tag_q;      // bit i set: read issued i cycles ago
    logic [CW-1:0]      occ_q;      // reads accepted and not yet popped
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [DWIDTH-1:0]  fifo_mem [RSP_DEPTH];

    logic acc, rd_acc, wr_acc, push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bus.req_ready   = run_q && (occ_q < CW'(RSP_DEPTH));
    assign acc             = bus.req_valid && bus.req_ready;
    assign rd_acc          = acc && !bus.req_write;
    // A zero-strobe write must not assert mem_en: with we=0 the URAM would perform a read.
    assign wr_acc          = acc && bus.req_write && (|bus.req_wstrb);
    assign push            = tag_q[LAT];
    assign pop             = bus.rsp_valid && bus.rsp_ready;

    assign bus.rsp_valid   = (cnt_q != '0);
    assign bus.rsp_rdata   = fifo_mem[rd_ptr_q];
    assign bus.uram_mem_en = en_q;
    assign bus.uram_we     = we_q;
    assign bus.uram_regce  = run_q;
    assign bus.uram_addr   = addr_q;
    assign bus.uram_din    = din_q;

    // Issue registers: one URAM access per accepted request; addr/din hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            en_q   <= 1'b0;
            we_q   <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            run_q <= 1'b1;
            en_q  <= rd_acc || wr_acc;
            we_q  <= wr_acc ? bus.req_wstrb : '0;
            if (acc) begin
                addr_q <= bus.req_addr;
            end
            if (wr_acc) begin
                din_q <= bus.req_wdata;
            end
        end
    end

    // Read tag pipeline and credit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
            occ_q <= '0;
        end else begin
            tag_q <= {tag_q[LAT-1:0], rd_acc};
            case ({rd_acc, pop})
                2'b10:   occ_q <= occ_q + CW'(1);
                2'b01:   occ_q <= occ_q - CW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Response FIFO: push when a tag exits, pop on handshake; credits rule out overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= bus.uram_dout;
                wr_ptr_q           <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_uram_req_rsp_adapter.sv
// Bench for uram_req_rsp_adapter with a pipelined URAM model and a transaction-level reference.
// Latency: expects rsp_valid NBPIPE+3 cycles after each read accept.
// Backpressure: drives rsp_ready low/random to exercise the credit limit.
module tb_uram_req_rsp_adapter;
    localparam int AW    = 12;
    localparam int NC    = 9;
    localparam int CWD   = 8;
    localparam int DW    = 72;
    localparam int NBP   = 3;
    localparam int DEPTH = 8;
    localparam int LAT   = NBP + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uram_req_rsp_adapter_if #(.AWIDTH(AW), .NUM_COL(NC), .DWIDTH(DW)) bus();

    uram_req_rsp_adapter #(
        .AWIDTH(AW), .NUM_COL(NC), .CWIDTH(CWD), .DWIDTH(DW), .NBPIPE(NBP), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // URAM model: samples at the edge after issue, data leaves LAT-1 edges later; garbage otherwise.
    logic [DW-1:0] umem [0:(1<<AW)-1];
    logic [DW-1:0] upipe [LAT];
    bit            umem_init = 1'b0;
    assign bus.uram_dout = upipe[LAT-1];

    always @(posedge clk) begin
        if (!umem_init) begin
            for (int i = 0; i < (1 << AW); i++) umem[i] <= '0;
            umem_init <= 1'b1;
        end else if (bus.uram_mem_en && (bus.uram_we != '0)) begin
            for (int l = 0; l < NC; l++)
                if (bus.uram_we[l]) umem[bus.uram_addr][l*CWD +: CWD] <= bus.uram_din[l*CWD +: CWD];
        end
        if (bus.uram_mem_en && (bus.uram_we == '0))
            upipe[0] <= umem[bus.uram_addr];
        else
            upipe[0] <= DW'({$urandom(), $urandom(), $urandom()});
        for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_q [$];
    int            rdy_q [$];
    int            cyc = 0;
    bit            rdy_en = 1'b0;
    bit            exp_valid = 1'b0;
    logic          exp_en = 1'b0;
    logic [NC-1:0] exp_we = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;
    bit            last_acc = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [NC-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int l = 0; l < NC; l++) if (s[l]) r[l*CWD +: CWD] = d[l*CWD +: CWD];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd72();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit v, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NC-1:0] s);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
    endtask

    task automatic check_outputs();
        chk("req_ready", DW'(bus.req_ready), DW'(rdy_en && (exp_q.size() < DEPTH)));
        chk("rsp_valid", DW'(bus.rsp_valid), DW'(exp_valid));
        if (exp_valid) chk("rsp_rdata", bus.rsp_rdata, exp_q[0]);
        chk("uram_mem_en", DW'(bus.uram_mem_en), DW'(exp_en));
        chk("uram_we", DW'(bus.uram_we), DW'(exp_we));
        chk("uram_addr", DW'(bus.uram_addr), DW'(exp_addr));
        chk("uram_din", bus.uram_din, exp_din);
        chk("uram_regce", DW'(bus.uram_regce), DW'(rdy_en));
    endtask

    // One clock: decide handshakes from the model, advance it, then compare at edge+1.
    task automatic tick();
        bit acc, pop, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NC-1:0] s;
        acc = bus.req_valid && rdy_en && (exp_q.size() < DEPTH) && !rst;
        pop = exp_valid && bus.rsp_ready;
        w = bus.req_write; a = bus.req_addr; d = bus.req_wdata; s = bus.req_wstrb;
        @(posedge clk);
        #1;
        cyc++;
        rdy_en = !rst;
        if (pop) begin
            void'(exp_q.pop_front());
            void'(rdy_q.pop_front());
        end
        exp_en = 1'b0;
        exp_we = '0;
        if (acc) begin
            exp_addr = a;
            if (!w) begin
                exp_q.push_back(ref_rd(int'(a)));
                rdy_q.push_back(cyc + LAT + 1);
                exp_en = 1'b1;
            end else if (s != '0) begin
                exp_en  = 1'b1;
                exp_we  = s;
                exp_din = d;
                ref_mem[int'(a)] = merge(ref_rd(int'(a)), d, s);
            end
        end
        last_acc  = acc;
        exp_valid = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        exp_q.delete();
        rdy_q.delete();
        rdy_en = 1'b0; exp_valid = 1'b0; exp_en = 1'b0;
        exp_we = '0; exp_addr = '0; exp_din = '0;
        chk("rst_rsp_valid", DW'(bus.rsp_valid), '0);
        chk("rst_req_ready", DW'(bus.req_ready), '0);
        chk("rst_mem_en", DW'(bus.uram_mem_en), '0);
        chk("rst_we", DW'(bus.uram_we), '0);
        chk("rst_regce", DW'(bus.uram_regce), '0);
        chk("rst_addr", DW'(bus.uram_addr), '0);
        chk("rst_din", bus.uram_din, '0);
        chk("rst_rdata", bus.rsp_rdata, '0);
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] data, output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        data = bus.rsp_rdata;
    endtask

    task automatic idle(input int n);
        set_req(1'b0, 1'b0, '0, '0, '0);
        repeat (n) tick();
    endtask

    initial begin
        logic [DW-1:0] data;
        logic [NC-1:0] s;
        int lat, nacc, ndrop, nstale;

        set_req(1'b0, 1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b1;
        #2;
        do_reset(3);
        tick();

        // Full write then read-back with latency check.
        set_req(1'b1, 1'b1, 12'h010, 72'h0A0102030405060708, 9'h1FF);
        tick();
        chk("t1_we", DW'(bus.uram_we), DW'(9'h1FF));
        set_req(1'b1, 1'b0, 12'h010, '0, '0);
        tick();
        chk("t1_we_once", DW'(bus.uram_we), '0);
        set_req(1'b0, 1'b0, '0, '0, '0);
        wait_rsp(data, lat);
        chk("t1_lat", DW'(lat), DW'(6));
        chk("t1_data", data, 72'h0A0102030405060708);
        idle(2);

        // Single-lane partial write.
        set_req(1'b1, 1'b1, 12'h010, {64'hDEAD_BEEF_CAFE_F00D, 8'hFF}, 9'h001);
        tick();
        set_req(1'b1, 1'b0, 12'h010, '0, '0);
        tick();
        set_req(1'b0, 1'b0, '0, '0, '0);
        wait_rsp(data, lat);
        chk("t2_data", data, 72'h0A01020304050607FF);
        idle(2);

        // Zero-strobe write is dropped.
        set_req(1'b1, 1'b1, 12'h020, 72'h55, 9'h1FF);
        tick();
        set_req(1'b1, 1'b1, 12'h020, 72'hAA_AAAA_AAAA_AAAA_AAAA, 9'h000);
        tick();
        chk("t3_mem_en", DW'(bus.uram_mem_en), '0);
        set_req(1'b1, 1'b0, 12'h020, '0, '0);
        tick();
        set_req(1'b0, 1'b0, '0, '0, '0);
        wait_rsp(data, lat);
        chk("t3_data", data, 72'h55);
        idle(8);

        // Credit limit with consumer stalled.
        for (int i = 0; i < 10; i++) begin
            set_req(1'b1, 1'b1, AW'(12'h100 + i), rnd72(), 9'h1FF);
            tick();
        end
        bus.rsp_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            set_req(1'b1, 1'b0, AW'(12'h100 + nacc), '0, '0);
            tick();
            if (last_acc) nacc++;
        end
        chk("t4_accepted", DW'(nacc), DW'(8));
        chk("t4_ready_low", DW'(bus.req_ready), '0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 40 && !(nacc == 10 && exp_q.size() == 0); c++) begin
            if (nacc < 10) set_req(1'b1, 1'b0, AW'(12'h100 + nacc), '0, '0);
            else           set_req(1'b0, 1'b0, '0, '0, '0);
            tick();
            if (last_acc) nacc++;
        end
        chk("t4_all_accepted", DW'(nacc), DW'(10));
        chk("t4_drained", DW'(bus.rsp_valid), '0);

        // Streaming reads at full rate.
        for (int i = 0; i < 16; i++) begin
            set_req(1'b1, 1'b1, AW'(i), rnd72(), 9'h1FF);
            tick();
        end
        ndrop = 0;
        for (int i = 0; i < 16; i++) begin
            set_req(1'b1, 1'b0, AW'(i), '0, '0);
            if (!bus.req_ready) ndrop++;
            tick();
        end
        chk("t5_ready_drops", DW'(ndrop), '0);
        idle(10);

        // Reset with reads in flight.
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, AW'(12'h100 + i), '0, '0);
            tick();
        end
        set_req(1'b0, 1'b0, '0, '0, '0);
        do_reset(2);
        nstale = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.rsp_valid) nstale++;
        end
        chk("t6_no_stale", DW'(nstale), '0);
        bus.rsp_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            set_req(1'b1, 1'b0, AW'(12'h100 + nacc), '0, '0);
            tick();
            if (last_acc) nacc++;
        end
        chk("t6_accepted", DW'(nacc), DW'(8));
        bus.rsp_ready = 1'b1;
        idle(16);

        // Random mix of reads, writes, zero strobes and consumer stalls.
        for (int c = 0; c < 400; c++) begin
            s = ($urandom_range(0, 5) == 0) ? '0 : NC'($urandom());
            set_req(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    AW'(12'h200 + $urandom_range(0, 7)), rnd72(), s);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.rsp_ready = 1'b1;
        idle(20);
        chk("final_empty", DW'(bus.rsp_valid), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
